// File: rtl/wr_txn_monitor.sv
// Multi-slot AXI write-transaction timer: tracks AW/W/B phases per slot with
// saturating per-phase latency counters and sticky per-slot budget timeouts.
module wr_txn_monitor #(
  parameter int unsigned NumSlots = 4,
  parameter int unsigned CntWidth = 8,
  parameter int unsigned IdWidth  = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        aw_valid_i,
  input  logic                        aw_ready_i,
  input  logic [IdWidth-1:0]          aw_id_i,
  input  logic                        w_valid_i,
  input  logic                        w_ready_i,
  input  logic                        w_last_i,
  input  logic                        b_valid_i,
  input  logic                        b_ready_i,
  input  logic [IdWidth-1:0]          b_id_i,
  input  logic [5*CntWidth-1:0]       budget_i,
  input  logic                        clr_timeout_i,
  output logic [NumSlots-1:0]         slot_busy_o,
  output logic                        full_o,
  output logic [NumSlots-1:0]         timed_out_o,
  output logic                        timeout_o,
  output logic                        timeout_pulse_o,
  output logic [$clog2(NumSlots)-1:0] timeout_slot_o,
  output logic [2:0]                  timeout_phase_o,
  output logic                        w_orphan_o,
  output logic                        b_orphan_o,
  output logic                        drop_o
);

  localparam int unsigned PtrW  = $clog2(NumSlots);
  localparam int unsigned NumPh = 5;

  // Busy encodings equal the reported phase number; FREE sits outside 0..4.
  typedef enum logic [2:0] {
    S_AW      = 3'd0,
    S_W_WAIT  = 3'd1,
    S_W_BURST = 3'd2,
    S_B_WAIT  = 3'd3,
    S_B_HS    = 3'd4,
    S_FREE    = 3'd7
  } slot_state_e;

  slot_state_e         r_state     [NumSlots];
  slot_state_e         w_state_nxt [NumSlots];
  logic [IdWidth-1:0]  r_id        [NumSlots];
  logic [CntWidth-1:0] r_cnt       [NumSlots][NumPh];
  logic [CntWidth-1:0] w_budget    [NumPh];

  logic [PtrW-1:0]     r_alloc_ptr;
  logic [PtrW-1:0]     r_w_ptr;
  logic [PtrW-1:0]     r_aw_slot;
  logic                r_aw_pend;
  logic [NumSlots-1:0] r_timed_out;
  logic                r_timeout_pulse;
  logic [PtrW-1:0]     r_timeout_slot;
  logic [2:0]          r_timeout_phase;
  logic                r_w_orphan;
  logic                r_b_orphan;
  logic                r_drop;

  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_alloc;
  logic                w_drop;
  logic                w_w_orphan;
  logic                w_w_adv;
  logic                w_b_orphan;
  logic                w_b_found;
  logic [PtrW-1:0]     w_b_slot;
  logic [PtrW-1:0]     w_idx;
  logic [NumSlots-1:0] w_tmo_hit;
  logic                w_tmo_any;
  logic [PtrW-1:0]     w_tmo_slot;
  logic [2:0]          w_tmo_phase;

  always_comb begin
    for (int unsigned p = 0; p < NumPh; p++) begin
      w_budget[p] = budget_i[p*CntWidth +: CntWidth];
    end
  end

  always_comb begin
    w_aw_hs    = aw_valid_i & aw_ready_i;
    w_w_hs     = w_valid_i & w_ready_i;
    w_alloc    = 1'b0;
    w_drop     = 1'b0;
    w_w_orphan = 1'b0;
    w_w_adv    = 1'b0;
    w_b_orphan = 1'b0;
    w_b_found  = 1'b0;
    w_b_slot   = '0;
    w_idx      = '0;
    for (int unsigned i = 0; i < NumSlots; i++) begin
      w_state_nxt[i] = r_state[i];
    end

    if (aw_valid_i && !r_aw_pend) begin
      if (r_state[r_alloc_ptr] == S_FREE) begin
        w_alloc = 1'b1;
        w_state_nxt[r_alloc_ptr] = aw_ready_i ? S_W_WAIT : S_AW;
      end else begin
        w_drop = 1'b1;
      end
    end else if (r_aw_pend && w_aw_hs) begin
      w_state_nxt[r_aw_slot] = S_W_WAIT;
    end

    if (w_w_hs) begin
      if (r_state[r_w_ptr] == S_W_WAIT || r_state[r_w_ptr] == S_W_BURST) begin
        w_state_nxt[r_w_ptr] = w_last_i ? S_B_WAIT : S_W_BURST;
        w_w_adv = w_last_i;
      end else begin
        w_w_orphan = 1'b1;
      end
    end

    // Cyclic search from alloc_ptr yields the oldest outstanding match.
    for (int unsigned k = 0; k < NumSlots; k++) begin
      w_idx = r_alloc_ptr + PtrW'(k);
      if (!w_b_found && (r_state[w_idx] == S_B_WAIT || r_state[w_idx] == S_B_HS)
          && r_id[w_idx] == b_id_i) begin
        w_b_found = 1'b1;
        w_b_slot  = w_idx;
      end
    end

    if (b_valid_i) begin
      if (w_b_found) begin
        if (b_ready_i) begin
          w_state_nxt[w_b_slot] = S_FREE;
        end else if (r_state[w_b_slot] == S_B_WAIT) begin
          w_state_nxt[w_b_slot] = S_B_HS;
        end
      end else if (b_ready_i) begin
        w_b_orphan = 1'b1;
      end
    end
  end

  always_comb begin
    w_tmo_hit   = '0;
    w_tmo_any   = 1'b0;
    w_tmo_slot  = '0;
    w_tmo_phase = '0;
    for (int unsigned i = 0; i < NumSlots; i++) begin
      for (int unsigned p = 0; p < NumPh; p++) begin
        if (3'(r_state[i]) == 3'(p) && w_budget[p] != '0 &&
            r_cnt[i][p] == w_budget[p] && !r_timed_out[i]) begin
          w_tmo_hit[i] = 1'b1;
        end
      end
      if (w_tmo_hit[i] && !w_tmo_any) begin
        w_tmo_any   = 1'b1;
        w_tmo_slot  = PtrW'(i);
        w_tmo_phase = 3'(r_state[i]);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NumSlots; i++) begin
        r_state[i] <= S_FREE;
        r_id[i]    <= '0;
        for (int unsigned p = 0; p < NumPh; p++) begin
          r_cnt[i][p] <= '0;
        end
      end
      r_alloc_ptr     <= '0;
      r_w_ptr         <= '0;
      r_aw_slot       <= '0;
      r_aw_pend       <= 1'b0;
      r_timed_out     <= '0;
      r_timeout_pulse <= 1'b0;
      r_timeout_slot  <= '0;
      r_timeout_phase <= '0;
      r_w_orphan      <= 1'b0;
      r_b_orphan      <= 1'b0;
      r_drop          <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NumSlots; i++) begin
        r_state[i] <= w_state_nxt[i];
        for (int unsigned p = 0; p < NumPh; p++) begin
          if (w_alloc && r_alloc_ptr == PtrW'(i)) begin
            r_cnt[i][p] <= '0;
          end else if (3'(r_state[i]) == 3'(p) && r_cnt[i][p] != '1) begin
            r_cnt[i][p] <= r_cnt[i][p] + CntWidth'(1);
          end
        end
      end

      if (w_alloc) begin
        r_id[r_alloc_ptr] <= aw_id_i;
        r_alloc_ptr       <= r_alloc_ptr + PtrW'(1);
        r_aw_slot         <= r_alloc_ptr;
        r_aw_pend         <= !aw_ready_i;
      end else if (r_aw_pend && w_aw_hs) begin
        r_aw_pend <= 1'b0;
      end

      if (w_w_adv) begin
        r_w_ptr <= r_w_ptr + PtrW'(1);
      end

      // A same-cycle new timeout survives the clear.
      r_timed_out     <= (clr_timeout_i ? '0 : r_timed_out) | w_tmo_hit;
      r_timeout_pulse <= w_tmo_any;
      r_timeout_slot  <= w_tmo_slot;
      r_timeout_phase <= w_tmo_phase;
      r_w_orphan      <= w_w_orphan;
      r_b_orphan      <= w_b_orphan;
      r_drop          <= w_drop;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NumSlots; i++) begin
      slot_busy_o[i] = (r_state[i] != S_FREE);
    end
  end

  assign full_o          = (r_state[r_alloc_ptr] != S_FREE);
  assign timed_out_o     = r_timed_out;
  assign timeout_o       = |r_timed_out;
  assign timeout_pulse_o = r_timeout_pulse;
  assign timeout_slot_o  = r_timeout_slot;
  assign timeout_phase_o = r_timeout_phase;
  assign w_orphan_o      = r_w_orphan;
  assign b_orphan_o      = r_b_orphan;
  assign drop_o          = r_drop;

endmodule

// File: tb/tb_wr_txn_monitor.sv
// Directed self-checking bench for wr_txn_monitor (4 slots, 8-bit counters).
module tb_wr_txn_monitor;
  localparam int unsigned NS = 4;
  localparam int unsigned CW = 8;
  localparam int unsigned IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready, clr;
  logic [IW-1:0] aw_id, b_id;
  logic [5*CW-1:0] budget;
  logic [NS-1:0] busy, timed_out;
  logic          full, tmo, tmo_pulse, w_orphan, b_orphan, drop;
  logic [1:0]    tmo_slot;
  logic [2:0]    tmo_phase;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [3:0]  ids [4];

  always #5 clk = ~clk;

  wr_txn_monitor #(.NumSlots(NS), .CntWidth(CW), .IdWidth(IW)) dut (
    .clk_i(clk), .rst_i(rst),
    .aw_valid_i(aw_valid), .aw_ready_i(aw_ready), .aw_id_i(aw_id),
    .w_valid_i(w_valid), .w_ready_i(w_ready), .w_last_i(w_last),
    .b_valid_i(b_valid), .b_ready_i(b_ready), .b_id_i(b_id),
    .budget_i(budget), .clr_timeout_i(clr),
    .slot_busy_o(busy), .full_o(full), .timed_out_o(timed_out), .timeout_o(tmo),
    .timeout_pulse_o(tmo_pulse), .timeout_slot_o(tmo_slot), .timeout_phase_o(tmo_phase),
    .w_orphan_o(w_orphan), .b_orphan_o(b_orphan), .drop_o(drop)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    aw_valid = 1'b0; aw_ready = 1'b0; aw_id = '0;
    w_valid = 1'b0; w_ready = 1'b0; w_last = 1'b0;
    b_valid = 1'b0; b_ready = 1'b0; b_id = '0;
    clr = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_timed_out"}, 32'(timed_out), 0);
    chk({tag, "_timeout"}, 32'(tmo), 0);
    chk({tag, "_pulse"}, 32'(tmo_pulse), 0);
    chk({tag, "_slot"}, 32'(tmo_slot), 0);
    chk({tag, "_phase"}, 32'(tmo_phase), 0);
    chk({tag, "_w_orphan"}, 32'(w_orphan), 0);
    chk({tag, "_b_orphan"}, 32'(b_orphan), 0);
    chk({tag, "_drop"}, 32'(drop), 0);
  endtask

  initial begin
    idle();
    budget = '0;
    rst = 1'b1;
    tick();
    tick();
    chk_quiet("reset");
    rst = 1'b0;

    // Single write, id 3, immediate handshakes, one beat.
    budget = {5{8'd5}};
    aw_valid = 1; aw_ready = 1; aw_id = 3;
    tick();
    chk("t1_busy_aw", 32'(busy), 32'h1);
    chk("t1_full", 32'(full), 0);
    idle(); w_valid = 1; w_ready = 1; w_last = 1;
    tick();
    chk("t1_busy_w", 32'(busy), 32'h1);
    chk("t1_w_orphan", 32'(w_orphan), 0);
    idle();
    tick();
    chk("t1_busy_bwait", 32'(busy), 32'h1);
    b_valid = 1; b_ready = 1; b_id = 3;
    tick();
    chk("t1_busy_freed", 32'(busy), 32'h0);
    chk("t1_b_orphan", 32'(b_orphan), 0);
    chk("t1_timeout", 32'(tmo), 0);
    idle(); aw_valid = 1; aw_ready = 1; aw_id = 5;
    tick();
    chk("t1_next_slot1", 32'(busy), 32'h2);
    do_reset();

    // AW stalled 10 cycles with AW budget 4.
    budget = 40'h00_00_00_00_04;
    aw_valid = 1; aw_ready = 0; aw_id = 2;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("t2_pulse_%0d", i), 32'(tmo_pulse), (i == 6) ? 32'h1 : 32'h0);
      chk($sformatf("t2_drop_%0d", i), 32'(drop), 0);
      if (i == 6) begin
        chk("t2_slot", 32'(tmo_slot), 0);
        chk("t2_phase", 32'(tmo_phase), 0);
        chk("t2_timed_out", 32'(timed_out), 32'h1);
      end
    end
    aw_ready = 1;
    tick();
    chk("t2_busy_after_hs", 32'(busy), 32'h1);
    idle(); w_valid = 1; w_ready = 1; w_last = 1;
    tick();
    idle(); b_valid = 1; b_ready = 1; b_id = 2;
    tick();
    idle();
    chk("t2_freed", 32'(busy), 32'h0);
    chk("t2_sticky", 32'(timed_out), 32'h1);
    chk("t2_timeout_o", 32'(tmo), 32'h1);
    clr = 1;
    tick();
    clr = 0;
    chk("t2_cleared", 32'(timed_out), 32'h0);
    chk("t2_timeout_o_clr", 32'(tmo), 32'h0);
    do_reset();

    // Four AWs (ids 1,1,2,1) fill the table; fifth drops; B id 1 frees oldest.
    budget = '0;
    ids = '{4'd1, 4'd1, 4'd2, 4'd1};
    for (int i = 0; i < 4; i++) begin
      aw_valid = 1; aw_ready = 1; aw_id = ids[i];
      tick();
    end
    chk("t3_busy_all", 32'(busy), 32'hF);
    chk("t3_full", 32'(full), 32'h1);
    aw_id = 7;
    tick();
    chk("t3_drop", 32'(drop), 32'h1);
    chk("t3_busy_drop", 32'(busy), 32'hF);
    idle();
    tick();
    chk("t3_drop_clear", 32'(drop), 32'h0);
    w_valid = 1; w_ready = 1; w_last = 1;
    repeat (4) tick();
    idle(); b_valid = 1; b_ready = 1; b_id = 1;
    tick();
    chk("t3_free_slot0", 32'(busy), 32'hE);
    chk("t3_not_full", 32'(full), 32'h0);
    tick();
    chk("t3_free_slot1", 32'(busy), 32'hC);
    do_reset();

    // Bursts of 4 and 2 beats with W_BURST budget 3, then a 5-beat burst.
    budget = 40'h00_00_03_00_00;
    aw_valid = 1; aw_ready = 1; aw_id = 4;
    tick();
    aw_id = 5;
    tick();
    idle(); w_valid = 1; w_ready = 1;
    for (int b = 0; b < 6; b++) begin
      w_last = (b == 3 || b == 5);
      tick();
      chk($sformatf("t4_nopulse_%0d", b), 32'(tmo_pulse), 0);
      chk($sformatf("t4_noorphan_%0d", b), 32'(w_orphan), 0);
    end
    w_last = 1;
    tick();
    chk("t4_w_orphan", 32'(w_orphan), 32'h1);
    idle();
    tick();
    chk("t4_w_orphan_clear", 32'(w_orphan), 32'h0);
    aw_valid = 1; aw_ready = 1; aw_id = 6;
    tick();
    chk("t4_busy3", 32'(busy), 32'h7);
    idle(); w_valid = 1; w_ready = 1;
    for (int b = 0; b < 5; b++) begin
      w_last = (b == 4);
      tick();
      chk($sformatf("t4_long_pulse_%0d", b), 32'(tmo_pulse), (b == 4) ? 32'h1 : 32'h0);
    end
    chk("t4_slot", 32'(tmo_slot), 32'h2);
    chk("t4_phase", 32'(tmo_phase), 32'h2);
    chk("t4_timed_out", 32'(timed_out), 32'h4);
    idle();
    tick();
    chk("t4_pulse_once", 32'(tmo_pulse), 32'h0);
    do_reset();

    // B held without ready 7 cycles with B_HS budget disabled; B orphan.
    budget = 40'h00_14_14_14_14;
    aw_valid = 1; aw_ready = 1; aw_id = 8;
    tick();
    idle(); w_valid = 1; w_ready = 1; w_last = 1;
    tick();
    idle(); b_valid = 1; b_ready = 0; b_id = 8;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("t5_nopulse_%0d", i), 32'(tmo_pulse), 0);
      chk($sformatf("t5_busy_%0d", i), 32'(busy), 32'h1);
    end
    b_ready = 1;
    tick();
    chk("t5_freed", 32'(busy), 32'h0);
    chk("t5_no_timeout", 32'(tmo), 32'h0);
    b_id = 9; b_ready = 0;
    tick();
    chk("t5_no_orphan_wo_hs", 32'(b_orphan), 32'h0);
    b_ready = 1;
    tick();
    chk("t5_b_orphan", 32'(b_orphan), 32'h1);
    idle();
    tick();
    chk("t5_b_orphan_clear", 32'(b_orphan), 32'h0);
    do_reset();

    // Reset mid-burst after a timeout discards everything.
    budget = 40'h00_00_00_00_02;
    aw_valid = 1; aw_ready = 0; aw_id = 3;
    repeat (4) tick();
    chk("t6_pulse", 32'(tmo_pulse), 32'h1);
    chk("t6_timed_out", 32'(timed_out), 32'h1);
    aw_ready = 1;
    tick();
    idle(); w_valid = 1; w_ready = 1; w_last = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    idle();
    chk_quiet("t6_rst");
    aw_valid = 1; aw_ready = 1; aw_id = 1;
    tick();
    idle();
    chk("t6_realloc_slot0", 32'(busy), 32'h1);
    chk("t6_flags_gone", 32'(timed_out), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/wr_txn_monitor.md
# wr_txn_monitor

Parametrised multi-slot write-transaction timer for the AXI monitor. It tracks up to NumSlots outstanding write transactions through the AW, W and B phases, each with its own internal phase FSM and per-phase saturating latency counters. Each counter is compared against a runtime budget, and a sticky timeout is raised per slot. It sits beside the monitored manager port, observes handshake signals only and never drives the bus.

## Interface
- NumSlots, 4: number of tracked outstanding writes, power of two, ≥2
- CntWidth, 8: width of each phase counter and budget
- IdWidth, 4: AXI ID width
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- aw_valid_i, aw_ready_i  in  1  AW handshake
- aw_id_i  in  IdWidth  AW ID
- w_valid_i, w_ready_i, w_last_i  in  1  W handshake and last beat
- b_valid_i, b_ready_i  in  1  B handshake
- b_id_i  in  IdWidth  B ID
- budget_i  in  5*CntWidth  per-phase budgets; phase p occupies bits [p*CntWidth +: CntWidth]; 0 disables that phase
- clr_timeout_i  in  1  clears all sticky timeout flags
- slot_busy_o  out  NumSlots  slot occupied
- full_o  out  1  slot at alloc pointer occupied
- timed_out_o  out  NumSlots  sticky per-slot timeout
- timeout_o  out  1  OR of timed_out_o
- timeout_pulse_o  out  1  one-cycle pulse on any new timeout
- timeout_slot_o  out  $clog2(NumSlots)  lowest slot newly timed out (valid with pulse)
- timeout_phase_o  out  3  phase of that slot (valid with pulse)
- w_orphan_o, b_orphan_o, drop_o  out  1  one-cycle error pulses

## Operation
- Phase encoding: 0 AW (awvalid→awready), 1 W_WAIT (AW handshake→first W beat), 2 W_BURST (first beat→wlast handshake), 3 B_WAIT (wlast→bvalid), 4 B_HS (bvalid→bready); plus FREE.
- Allocation: when aw_valid_i=1 and aw_pend_q=0, slot alloc_ptr is taken if free.
  - Stores aw_id_i and enters AW. If aw_ready_i=1 in the same cycle, it enters W_WAIT directly.
  - alloc_ptr then increments modulo NumSlots.
  - aw_pend_q is set while AW is pending, blocking re-allocation, and clears on the AW handshake.
  - If that slot is busy, nothing is allocated, drop_o pulses, and aw_pend_q stays 0.
- Allocation order is cyclic in index. "Oldest" means first busy slot searched cyclically from alloc_ptr.
- W routing: beats go to slot w_ptr (in-order AXI W). The beat applies only if that slot is in W_WAIT or W_BURST.
  - Any handshake beat moves W_WAIT→W_BURST.
  - A handshake beat with w_last_i=1 moves the slot to B_WAIT and advances w_ptr.
  - A single-beat burst goes W_WAIT→B_WAIT directly.
  - A beat arriving when w_ptr's slot is in neither state is ignored and pulses w_orphan_o.
- B routing: on b_valid_i, the oldest slot in B_WAIT/B_HS whose ID matches b_id_i is selected.
  - B_WAIT moves to B_HS when b_valid_i=1 and b_ready_i=0.
  - A handshake from either state frees the slot.
  - If no slot matches, b_orphan_o pulses once per handshake.
- Counters: each slot has 5 counters.
  - The counter of the current phase increments by 1 every cycle the slot is registered in that phase, saturating at all-ones.
  - Counters hold on phase exit and clear to 0 on allocation.
- Timeout: a slot times out when it is in phase p with budget p ≠ 0 and its counter equals the budget, and its flag is clear.
  - The flag is set the next cycle and timeout_pulse_o pulses.
  - A slot times out at most once until cleared. Freeing the slot does not clear the flag.
  - clr_timeout_i clears all flags. A new timeout in the same cycle as the clear wins.
- Simultaneous events: allocation, a W beat and a B handshake to different slots all act in the same cycle. A slot freed in cycle t is allocatable in cycle t+1.

## Timing
- Reset state: all slots FREE, counters 0, pointers 0, aw_pend_q 0, all outputs 0.
- Reset mid-operation discards all in-flight tracking and timeout flags.
- slot_busy_o rises the cycle after allocation and falls the cycle after the B handshake.
- A budget of N in phase p gives timeout_pulse_o N+1 cycles after the slot enters p, provided it is still in p.
- timeout_slot_o and timeout_phase_o are registered with the pulse.
- Error pulses are registered: one cycle after the offending event.
- full_o is combinational from slot state at alloc_ptr.

## Test plan
- Single write, id 3, all handshakes immediate, 1 beat, budgets 5 → slot0 busy for 3 cycles, freed, no timeout, alloc_ptr=1.
- aw_ready_i held low 10 cycles, budget AW=4 → timeout_pulse_o once, 5 cycles after allocation, slot 0, phase 0; timed_out_o[0] stays set after completion until clr_timeout_i.
- Four AW with ids 1,1,2,1, no B → full_o=1. A fifth AW gives drop_o. B id 1 frees slot 0 (oldest match), not slot 1 or 3.
- Bursts of 4 and 2 beats back-to-back → slot0 in W_BURST 3 counted cycles, then slot1 takes the next beats. A beat with no slot pending gives w_orphan_o.
- b_valid_i with b_ready_i low 7 cycles, budget B_HS=0 → no timeout. B id 9 not outstanding gives b_orphan_o.
- rst_i asserted mid-burst → next cycle all outputs 0. A new AW allocates slot 0.
